layer_input_loader: RTL and testbench

- Upstream feeder for the combinational fully-connected layer stage: 16 parallel-by-N inputs and OUT*IN weights.
- Accepts a serial 16-bit word stream over a valid/ready handshake.
- Assembles the words into the parallel input and weight arrays, then holds them stable while presenting them to the layer with a valid/ready handshake.
- Supports input-only frames that reuse previously loaded weights.

---
 rtl/dnn_pkg.sv | 16 +
 rtl/layer_input_loader.sv | 177 +++++++++++++++++
 tb/tb_layer_input_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// Shared definitions for the fully-connected layer datapath: word width,
// word type and the input loader's state set.
package dnn_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_IN = 2'd1,
    LOAD_W  = 2'd2,
    PRESENT = 2'd3
  } loader_state_t;

endpackage

// File: rtl/layer_input_loader.sv
// Deserialises a 16-bit word stream into the parallel input vector and
// weight matrix of the fully-connected layer, then holds them for the layer.
module layer_input_loader
  import dnn_pkg::*;
#(
  parameter int INPUT_NEURON_COUNT  = 15,
  parameter int OUTPUT_NEURON_COUNT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic              s_load_weights,
  output logic [WORD_W-1:0] m_inputs  [INPUT_NEURON_COUNT],
  output logic [WORD_W-1:0] m_weights [INPUT_NEURON_COUNT*OUTPUT_NEURON_COUNT],
  output logic              m_valid,
  input  logic              m_ready,
  output logic              weights_loaded,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int N       = INPUT_NEURON_COUNT;
  localparam int M       = OUTPUT_NEURON_COUNT;
  localparam int W_COUNT = M * N;
  localparam int CNT_MAX = (W_COUNT > N) ? W_COUNT : N;
  localparam int IDX_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_W  = IDX_W'(W_COUNT - 1);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_LOAD_IN = LOAD_IN;
  localparam logic [1:0] S_LOAD_W  = LOAD_W;
  localparam logic [1:0] S_PRESENT = PRESENT;

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             mode, mode_d;
  logic             valid_d;
  logic             wl_d;
  logic             err_set;
  logic             beat;
  logic             mode_eff;
  logic             last_in_word;
  logic             last_w_word;
  logic [N-1:0]     in_we;
  logic [W_COUNT-1:0] w_we;

  assign s_ready      = (state != S_PRESENT);
  assign beat         = s_valid && s_ready;
  // The frame mode is only known from s_load_weights on the first beat.
  assign mode_eff     = (state == S_IDLE) ? s_load_weights : mode;
  assign last_in_word = ((state == S_IDLE) && (N == 1)) ||
                        ((state == S_LOAD_IN) && (idx == LAST_IN));
  assign last_w_word  = (state == S_LOAD_W) && (idx == LAST_W);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    mode_d  = mode;
    valid_d = m_valid;
    wl_d    = weights_loaded;
    err_set = 1'b0;

    if (beat) begin
      if (state == S_IDLE) begin
        mode_d = s_load_weights;
      end

      if (last_in_word) begin
        idx_d = '0;
        if (mode_eff) begin
          if (s_last) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD_W;
          end
        end else if (weights_loaded) begin
          state_d = S_PRESENT;
          valid_d = 1'b1;
          err_set = !s_last;
        end else begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end else if (last_w_word) begin
        idx_d   = '0;
        wl_d    = 1'b1;
        state_d = S_PRESENT;
        valid_d = 1'b1;
        err_set = !s_last;
      end else if (s_last) begin
        // Early termination; a half-written weight set can no longer be trusted.
        idx_d   = '0;
        err_set = 1'b1;
        state_d = S_IDLE;
        if (state == S_LOAD_W) begin
          wl_d = 1'b0;
        end
      end else if (state == S_IDLE) begin
        idx_d   = IDX_W'(1);
        state_d = S_LOAD_IN;
      end else begin
        idx_d = idx + IDX_W'(1);
      end
    end

    if ((state == S_PRESENT) && m_ready) begin
      state_d = S_IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      mode           <= 1'b0;
      m_valid        <= 1'b0;
      weights_loaded <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      mode           <= mode_d;
      m_valid        <= valid_d;
      weights_loaded <= wl_d;
      frame_err      <= err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err);
    end
  end

  always_comb begin
    in_we = '0;
    w_we  = '0;
    for (int j = 0; j < N; j++) begin
      in_we[j] = beat && (((state == S_IDLE) && (j == 0)) ||
                          ((state == S_LOAD_IN) && (idx == IDX_W'(j))));
    end
    for (int k = 0; k < W_COUNT; k++) begin
      w_we[k] = beat && (state == S_LOAD_W) && (idx == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        m_inputs[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (in_we[j]) begin
          m_inputs[j] <= s_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < W_COUNT; k++) begin
        m_weights[k] <= '0;
      end
    end else begin
      for (int k = 0; k < W_COUNT; k++) begin
        if (w_we[k]) begin
          m_weights[k] <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_input_loader.sv
// Randomised frame-level bench for layer_input_loader (N=2, M=2) with a
// frame-outcome reference model.
module tb_layer_input_loader;
  import dnn_pkg::*;

  localparam int N  = 2;
  localparam int M  = 2;
  localparam int WC = N * M;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        s_load_weights;
  logic [15:0] m_inputs  [N];
  logic [15:0] m_weights [WC];
  logic        m_valid;
  logic        m_ready;
  logic        weights_loaded;
  logic        frame_err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  bit          mWl;
  bit          mErr;
  logic [15:0] mIn [N];
  logic [15:0] mW  [WC];

  logic [15:0] frameData [$];
  bit          frameLast [$];
  bit          clrOnFinal;

  layer_input_loader #(
    .INPUT_NEURON_COUNT (N),
    .OUTPUT_NEURON_COUNT(M)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_last        (s_last),
    .s_load_weights(s_load_weights),
    .m_inputs      (m_inputs),
    .m_weights     (m_weights),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .weights_loaded(weights_loaded),
    .frame_err     (frame_err),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compareArrays(input string tag);
    for (int j = 0; j < N; j++) checkOutput({tag, "_in"}, m_inputs[j], mIn[j]);
    for (int k = 0; k < WC; k++) checkOutput({tag, "_w"}, m_weights[k], mW[k]);
  endtask

  task automatic modelReset();
    mWl  = 0;
    mErr = 0;
    for (int j = 0; j < N; j++) mIn[j] = '0;
    for (int k = 0; k < WC; k++) mW[k] = '0;
  endtask

  // Fills the frame queues: random payload, optional early s_last or missing s_last.
  task automatic buildFrame(input bit lw, input bit early, input bit dropLast);
    int expLen = lw ? N + WC : N;
    int len    = expLen;
    frameData.delete();
    frameLast.delete();
    if (early) len = $urandom_range(1, expLen - 1);
    for (int p = 0; p < len; p++) begin
      frameData.push_back(16'($urandom));
      frameLast.push_back((p == len - 1) && !(dropLast && !early));
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    mErr = 0;
    checkOutput("err_clr", frame_err, 0);
  endtask

  task automatic applyStimulus(input bit lw);
    int  expLen = lw ? N + WC : N;
    int  endPos = frameData.size() - 1;
    bit  early  = 0;
    bit  present;
    bit  errNew;
    int  hold;

    for (int p = 0; p < frameData.size(); p++) begin
      if (frameLast[p] && (p < expLen - 1)) begin
        early  = 1;
        endPos = p;
        break;
      end
    end

    for (int p = 0; p <= endPos; p++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        s_valid        = 1'b0;
        s_data         = 16'($urandom);
        s_last         = 1'($urandom);
        s_load_weights = 1'($urandom);
        checkOutput("s_ready_gap", s_ready, 1);
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      s_valid        = 1'b1;
      s_data         = frameData[p];
      s_last         = frameLast[p];
      s_load_weights = (p == 0) ? lw : 1'($urandom);
      err_clr        = clrOnFinal && (p == endPos);
      checkOutput("s_ready_load", s_ready, 1);
      checkOutput("m_valid_load", m_valid, 0);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      err_clr = 1'b0;
    end

    if (early) begin
      errNew  = 1;
      present = 0;
      if (endPos >= N) mWl = 0;
    end else if (!lw && !mWl) begin
      errNew  = 1;
      present = 0;
    end else begin
      present = 1;
      errNew  = !frameLast[endPos];
      for (int j = 0; j < N; j++) mIn[j] = frameData[j];
      if (lw) begin
        for (int k = 0; k < WC; k++) mW[k] = frameData[N + k];
        mWl = 1;
      end
    end
    mErr = errNew ? 1'b1 : (clrOnFinal ? 1'b0 : mErr);

    checkOutput("m_valid_end", m_valid, present);
    checkOutput("s_ready_end", s_ready, !present);
    checkOutput("weights_loaded", weights_loaded, mWl);
    checkOutput("frame_err", frame_err, mErr);

    if (present) begin
      compareArrays("present");
      hold = $urandom_range(0, 5);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'($urandom);
        s_last  = 1'($urandom);
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("s_ready_hold", s_ready, 0);
        checkOutput("m_valid_hold", m_valid, 1);
        compareArrays("hold");
      end
      @(negedge clk);
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      checkOutput("m_valid_drop", m_valid, 0);
      checkOutput("s_ready_release", s_ready, 1);
      compareArrays("after");
    end
  endtask

  initial begin
    s_data = '0; s_valid = 0; s_last = 0; s_load_weights = 0;
    m_ready = 0; err_clr = 0; clrOnFinal = 0;
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_wl", weights_loaded, 0);
    checkOutput("rst_err", frame_err, 0);
    compareArrays("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // input-only frame with no weights held
    frameData = '{16'h0005, 16'h0006};
    frameLast = '{1'b0, 1'b1};
    applyStimulus(1'b0);
    pulseClear();

    // full frame from the plan
    frameData = '{16'h0001, 16'h0002, 16'h0010, 16'h0011, 16'h0012, 16'h0013};
    frameLast = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1);
    checkOutput("plan_w3", mW[3], 16'h0013);

    frameData = '{16'h0005, 16'h0006};
    frameLast = '{1'b0, 1'b1};
    applyStimulus(1'b0);

    // early s_last on the 3rd beat (first weight)
    frameData = '{16'h00a1, 16'h00a2, 16'h00a3};
    frameLast = '{1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1);
    pulseClear();

    buildFrame(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1);

    // missing s_last still presents
    buildFrame(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0);

    // error and clear in the same cycle: error wins
    clrOnFinal = 1;
    buildFrame(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1);
    clrOnFinal = 0;
    pulseClear();

    for (int f = 0; f < 60; f++) begin
      bit lw = 1'($urandom);
      buildFrame(lw, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      clrOnFinal = ($urandom_range(0, 7) == 0);
      applyStimulus(lw);
      clrOnFinal = 0;
      if (mErr && ($urandom_range(0, 1) == 1)) pulseClear();
    end

    // asynchronous reset in the middle of the weight phase
    for (int p = 0; p < N + 1; p++) begin
      @(negedge clk);
      s_valid        = 1'b1;
      s_data         = 16'h7000 + 16'(p);
      s_last         = 1'b0;
      s_load_weights = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("arst_m_valid", m_valid, 0);
    checkOutput("arst_wl", weights_loaded, 0);
    checkOutput("arst_err", frame_err, 0);
    compareArrays("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("arst_s_ready", s_ready, 1);

    buildFrame(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
